pattern_det_ctrl: RTL
=====================

// Module: pattern_det_ctrl
// PURPOSE
//  Controller for the serial bit-pattern detector datapath. It holds a programmable
//  pattern of 1..MAX_LEN bits and arms and disarms detection on a serial bit stream.
//  It counts matches with or without overlap and reports completion once a match
//  threshold is reached, or a timeout if a cycle window expires first.
//  It sits between the config/control source and the serial bit source; the fixed
//  "111" detector is the special case len=3, pattern=3'b111.
// PARAMETERS
//  MAX_LEN  8   max pattern length in bits (>=2)
//  CW       8   width of match counter and threshold
//  TW       16  width of timeout window counter
// PORTS  (LW = $clog2(MAX_LEN+1))
//  clk            in   1        rising-edge clock
//  reset          in   1        synchronous, active-high reset
//  cfg_pattern    in   MAX_LEN  pattern; bit [len-1] is first received, bit [0] is last
//  cfg_len        in   LW       pattern length; valid range 1..MAX_LEN
//  cfg_overlap    in   1        1 = overlapping matches allowed
//  cfg_threshold  in   CW       matches needed for done; 0 is treated as 1
//  cfg_window     in   TW       timeout in clocks after start; 0 = no timeout
//  start          in   1        pulse: latch config and arm
//  stop           in   1        pulse: abort and return to IDLE
//  bit_valid      in   1        bit_in is valid this cycle
//  bit_in         in   1        serial data bit
//  busy           out  1        1 while in ARMED
//  match          out  1        one-cycle pulse per detected match
//  match_count    out  CW       matches since last start; saturating
//  done           out  1        level: threshold reached
//  timeout        out  1        level: window expired before threshold
//  err            out  1        one-cycle pulse: start rejected because of bad cfg_len
// BEHAVIOUR
//  Reset (synchronous): state=IDLE, history and all counters cleared, all outputs 0.
//  FSM states: IDLE, ARMED, DONE, TMO.
//  IDLE/DONE/TMO + start with valid len -> ARMED:
//   - latch all cfg_* inputs;
//   - clear history, bits_seen, match_count, window counter, done and timeout.
//  IDLE/DONE/TMO + start with len 0 or len > MAX_LEN:
//   - err=1 for one cycle; state and outputs otherwise unchanged.
//  ARMED: start ignored, cfg_* changes ignored (latched copy in use).
//  ARMED + stop -> IDLE next edge; match_count holds its value.
//   - stop and start in the same cycle: stop wins.
//  Stop outside ARMED: no effect.
//  Bit accept (ARMED and bit_valid):
//   - history shifts left, bit_in enters at bit 0;
//   - bits_seen increments, saturating at MAX_LEN.
//  Match test: bits_seen after the shift >= len and history[len-1:0] == pattern[len-1:0].
//  Match latency: match is high in the cycle after the edge that accepts the completing bit.
//  Cycles with bit_valid=0: no shift, no match test.
//  Overlap=0: bits_seen is cleared on each match, so the next match needs len fresh bits.
//  Overlap=1: history is kept after a match.
//  match_count increments on each match and saturates at 2^CW-1.
//  Threshold: the match that brings match_count to threshold moves the FSM to DONE.
//   - done rises in the same cycle as that match pulse; busy falls.
//  Window: counts every clock in ARMED, from 1 on the first ARMED cycle.
//   - reaching cfg_window (when nonzero) -> TMO; timeout=1, busy=0.
//  Simultaneous threshold match and window expiry: DONE wins, timeout stays 0.
//  In DONE/TMO: outputs hold, bits are ignored, match is 0.
//  Reset mid-operation: returns to the reset state on the next edge, overriding everything.
// TESTING
//  T1 len=3, pat=111, ovl=1, thr=3, win=0; bits 1,1,1,1,1 ->
//     match after bits 3,4,5; count=3; done after bit 5.
//  T2 len=3, pat=111, ovl=0, thr=4; bits 1x6 ->
//     match after bits 3 and 6 only; count=2; busy stays 1.
//  T3 len=4, pat=1011, ovl=1, thr=2; bits 1,0,1,1,0,1,1 -> match after bits 4 and 7; done.
//  T4 win=10, thr=1, bits all 0 -> timeout=1 and busy=0 ten clocks after start;
//     a later start clears timeout.
//  T5 bit_valid gaps between 1s still give a match.
//     stop at count=1 -> IDLE, count holds 1.
//     start and stop in the same cycle -> stays IDLE.
//  T6 cfg_len=0 with start -> err pulse, state stays IDLE.
//     reset asserted while ARMED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_det_ctrl.sv
// Serial bit-pattern detector controller: programmable pattern, match counting,
// threshold completion and cycle-window timeout.
module pattern_det_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CW      = 8,
    parameter int unsigned TW      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CW-1:0]                cfg_threshold,
    input  logic [TW-1:0]                cfg_window,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    output logic                         busy,
    output logic                         match,
    output logic [CW-1:0]                match_count,
    output logic                         done,
    output logic                         timeout,
    output logic                         err
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2,
        S_TMO   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      seen_q, seen_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      wcnt_q, wcnt_d;

    // latched configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CW-1:0]      thr_q, thr_d;
    logic [TW-1:0]      win_q, win_d;

    logic               match_d, err_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [CW-1:0]      thr_eff;
    logic               len_ok;

    // mask selecting the low len_q history bits
    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    assign thr_eff = (thr_q == '0) ? CW'(1) : thr_q;
    assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    // next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        thr_d   = thr_q;
        win_d   = win_q;
        match_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_ARMED: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    if (bit_valid) begin
                        hist_d = {hist_q[MAX_LEN-2:0], bit_in};
                        seen_d = (seen_q == LEN_MAX) ? seen_q : seen_q + LW'(1);
                        if ((seen_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0)) begin
                            match_d = 1'b1;
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + CW'(1);
                            end
                            if (!ovl_q) begin
                                seen_d = '0;
                            end
                            if (cnt_d == thr_eff) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                    if (win_q != '0) begin
                        wcnt_d = wcnt_q + TW'(1);
                        // threshold completion takes priority over expiry
                        if ((state_d == S_ARMED) && (wcnt_d == win_q)) begin
                            state_d = S_TMO;
                        end
                    end
                end
            end
            default: begin
                if (start && !stop) begin
                    if (len_ok) begin
                        state_d = S_ARMED;
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        thr_d   = cfg_threshold;
                        win_d   = cfg_window;
                        hist_d  = '0;
                        seen_d  = '0;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            seen_q      <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            thr_q       <= '0;
            win_q       <= '0;
            busy        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            thr_q       <= thr_d;
            win_q       <= win_d;
            busy        <= (state_d == S_ARMED);
            match       <= match_d;
            match_count <= cnt_d;
            done        <= (state_d == S_DONE);
            timeout     <= (state_d == S_TMO);
            err         <= err_d;
        end
    end

endmodule
